// File: rtl/irq_dispatch_if.sv
// Bundle of the peripheral, CSR and core-facing signals of the interrupt dispatcher.
// The slave side is the dispatcher; the master side drives sources and takes requests.
interface irq_dispatch_if #(
  parameter int NumIrq    = 8,
  parameter int PrioWidth = 3,
  parameter int IdWidth   = (NumIrq > 1) ? $clog2(NumIrq) : 1
);
  logic [NumIrq-1:0]           irq_set;
  logic [NumIrq-1:0]           irq_enable;
  logic [NumIrq*PrioWidth-1:0] irq_prio;
  logic [NumIrq-1:0]           sw_set;
  logic [NumIrq-1:0]           sw_clear;
  logic [PrioWidth-1:0]        current_prio;
  logic                        take;
  logic                        req_valid;
  logic [IdWidth-1:0]          req_id;
  logic [PrioWidth-1:0]        req_prio;
  logic [NumIrq-1:0]           irq_clear;
  logic [NumIrq-1:0]           pending;

  modport master (
    output irq_set, irq_enable, irq_prio, sw_set, sw_clear, current_prio, take,
    input  req_valid, req_id, req_prio, irq_clear, pending
  );

  modport slave (
    input  irq_set, irq_enable, irq_prio, sw_set, sw_clear, current_prio, take,
    output req_valid, req_id, req_prio, irq_clear, pending
  );
endinterface

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: edge-detects peripheral interrupt levels, latches pending bits,
// arbitrates by priority against the core's running priority and pulses irq_clear on take.
//
// state | meaning
// IDLE  | nothing eligible, req_valid low
// REQ   | request presented, re-arbitrated every cycle until take
// ACK   | one-cycle clear pulse to the taken source, req_valid low
module irq_dispatch #(
  parameter int NumIrq    = 8,
  parameter int PrioWidth = 3,
  parameter int IdWidth   = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
  input logic           clk,
  input logic           reset,
  irq_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

  state_e               state_q, state_d;
  logic [NumIrq-1:0]    irq_prev;
  logic [NumIrq-1:0]    pending_q, pending_d;
  logic [NumIrq-1:0]    irq_clear_q, irq_clear_d;
  logic [NumIrq-1:0]    take_mask;
  logic                 take_ok;
  logic                 req_valid_q, req_valid_d;
  logic [IdWidth-1:0]   req_id_q, req_id_d, win_id;
  logic [PrioWidth-1:0] req_prio_q, req_prio_d, win_prio;
  logic                 any_elig;

  // Ascending scan with strict '>' keeps the lowest index on equal priority.
  always_comb begin
    any_elig = 1'b0;
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NumIrq; i++) begin
      if (pending_q[i] && bus.irq_enable[i] &&
          (bus.irq_prio[i*PrioWidth +: PrioWidth] > bus.current_prio) &&
          (!any_elig || (bus.irq_prio[i*PrioWidth +: PrioWidth] > win_prio))) begin
        any_elig = 1'b1;
        win_id   = IdWidth'(i);
        win_prio = bus.irq_prio[i*PrioWidth +: PrioWidth];
      end
    end
  end

  assign take_ok   = (state_q == REQ) && bus.take;
  assign take_mask = take_ok ? (NumIrq'(1) << req_id_q) : '0;
  // Set terms are OR-ed last so a fresh event always survives a same-cycle clear.
  assign pending_d = (pending_q & ~bus.sw_clear & ~take_mask) | (bus.irq_set & ~irq_prev) | bus.sw_set;

  always_comb begin
    state_d     = state_q;
    req_valid_d = 1'b0;
    req_id_d    = '0;
    req_prio_d  = '0;
    irq_clear_d = '0;
    case (state_q)
      IDLE, ACK: begin
        if (any_elig) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_id_d    = win_id;
          req_prio_d  = win_prio;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.take) begin
          state_d     = ACK;
          irq_clear_d = take_mask;
        end else if (any_elig) begin
          req_valid_d = 1'b1;
          req_id_d    = win_id;
          req_prio_d  = win_prio;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      irq_clear_q <= '0;
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_prio_q  <= '0;
      // Track the live level so a source held high across reset is not seen as a new edge.
      irq_prev    <= bus.irq_set;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      irq_clear_q <= irq_clear_d;
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_prio_q  <= req_prio_d;
      irq_prev    <= bus.irq_set;
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.req_id    = req_id_q;
  assign bus.req_prio  = req_prio_q;
  assign bus.irq_clear = irq_clear_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: directed scenarios plus a randomized run
// against a cycle-level reference model of the pending/arbitration rules.
module tb_irq_dispatch;
  localparam int N  = 8;
  localparam int PW = 3;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  irq_dispatch_if #(.NumIrq(N), .PrioWidth(PW), .IdWidth(IW)) bus ();

  irq_dispatch #(.NumIrq(N), .PrioWidth(PW), .IdWidth(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: pending set/clear rules plus "present the best eligible source,
  // drop for one cycle after a take".
  logic [N-1:0] m_pend, m_prev, m_clear;
  logic         m_valid;
  int           m_id, m_prio;

  always @(posedge clk) begin
    logic took;
    int   best_s, best_i, p;
    if (reset) begin
      m_pend  = '0;
      m_prev  = bus.irq_set;
      m_clear = '0;
      m_valid = 1'b0;
      m_id    = 0;
      m_prio  = 0;
    end else begin
      took   = m_valid && bus.take;
      best_s = -1;
      best_i = 0;
      for (int i = 0; i < N; i++) begin
        p = int'(bus.irq_prio[i*PW +: PW]);
        if (m_pend[i] && bus.irq_enable[i] && p > int'(bus.current_prio) &&
            p * 64 + (63 - i) > best_s) begin
          best_s = p * 64 + (63 - i);
          best_i = i;
        end
      end
      m_clear = took ? (N'(1) << m_id) : '0;
      for (int i = 0; i < N; i++) begin
        if ((bus.irq_set[i] && !m_prev[i]) || bus.sw_set[i]) m_pend[i] = 1'b1;
        else if (bus.sw_clear[i] || (took && m_id == i))     m_pend[i] = 1'b0;
      end
      m_prev = bus.irq_set;
      if (took) m_valid = 1'b0;
      else begin
        m_valid = (best_s >= 0);
        m_id    = best_i;
        m_prio  = best_s >= 0 ? best_s / 64 : 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_prio(input int idx, input int p);
    bus.irq_prio[idx*PW +: PW] = PW'(p);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sw_set = 8'hFF;
    tick(); tick();
    n_checks++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.req_valid); end
    n_checks++; if (bus.req_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.req_id); end
    n_checks++; if (bus.req_prio !== 3'd0) begin n_fail++; $display("FAIL reset_prio: got %0d want 0", bus.req_prio); end
    n_checks++; if (bus.irq_clear !== 8'h00) begin n_fail++; $display("FAIL reset_clear: got %h want 00", bus.irq_clear); end
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", bus.pending); end
    bus.sw_set = '0;
    reset = 1'b0;
    tick();
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL reset_release_pending: got %h want 00", bus.pending); end
  endtask

  task automatic test_single();
    set_prio(2, 3);
    bus.irq_set[2] = 1'b1;
    tick();
    n_checks++; if (bus.pending !== 8'h04) begin n_fail++; $display("FAIL single_pending: got %h want 04", bus.pending); end
    n_checks++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b want 0", bus.req_valid); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd2 || bus.req_prio !== 3'd3) begin
      n_fail++; $display("FAIL single_req: got v=%b id=%0d p=%0d want v=1 id=2 p=3", bus.req_valid, bus.req_id, bus.req_prio); end
    tick();
    bus.take = 1'b1;
    tick();
    bus.take = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h04) begin n_fail++; $display("FAIL single_clear: got %h want 04", bus.irq_clear); end
    n_checks++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack_valid: got %b want 0", bus.req_valid); end
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL single_ack_pending: got %h want 00", bus.pending); end
    tick();
    n_checks++; if (bus.irq_clear !== 8'h00 || bus.pending !== 8'h00 || bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_held: got clr=%h pend=%h v=%b want 00 00 0", bus.irq_clear, bus.pending, bus.req_valid); end
    bus.irq_set = '0;
    bus.irq_prio = '0;
    tick();
  endtask

  task automatic test_priority();
    set_prio(1, 2); set_prio(5, 6); set_prio(6, 6);
    bus.irq_set = 8'h62;
    tick(); tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd5) begin
      n_fail++; $display("FAIL prio_first: got v=%b id=%0d want v=1 id=5", bus.req_valid, bus.req_id); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h20) begin n_fail++; $display("FAIL prio_clear5: got %h want 20", bus.irq_clear); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd6 || bus.req_prio !== 3'd6) begin
      n_fail++; $display("FAIL prio_second: got v=%b id=%0d p=%0d want v=1 id=6 p=6", bus.req_valid, bus.req_id, bus.req_prio); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h40) begin n_fail++; $display("FAIL prio_clear6: got %h want 40", bus.irq_clear); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd1 || bus.req_prio !== 3'd2) begin
      n_fail++; $display("FAIL prio_third: got v=%b id=%0d p=%0d want v=1 id=1 p=2", bus.req_valid, bus.req_id, bus.req_prio); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h02 || bus.pending !== 8'h00) begin
      n_fail++; $display("FAIL prio_last: got clr=%h pend=%h want 02 00", bus.irq_clear, bus.pending); end
    bus.irq_set = '0; bus.irq_prio = '0;
    tick();
  endtask

  task automatic test_preempt();
    set_prio(0, 1); set_prio(3, 4);
    bus.irq_set[0] = 1'b1;
    tick(); tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd0) begin
      n_fail++; $display("FAIL preempt_initial: got v=%b id=%0d want v=1 id=0", bus.req_valid, bus.req_id); end
    bus.irq_set[3] = 1'b1;
    tick();
    n_checks++; if (bus.req_id !== 3'd0) begin n_fail++; $display("FAIL preempt_early: got id=%0d want 0", bus.req_id); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd3 || bus.req_prio !== 3'd4) begin
      n_fail++; $display("FAIL preempt_switch: got v=%b id=%0d p=%0d want v=1 id=3 p=4", bus.req_valid, bus.req_id, bus.req_prio); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h08 || bus.pending !== 8'h01) begin
      n_fail++; $display("FAIL preempt_ack: got clr=%h pend=%h want 08 01", bus.irq_clear, bus.pending); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd0) begin
      n_fail++; $display("FAIL preempt_resume: got v=%b id=%0d want v=1 id=0", bus.req_valid, bus.req_id); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    bus.irq_set = '0; bus.irq_prio = '0;
    tick();
  endtask

  task automatic test_threshold();
    set_prio(4, 2);
    bus.current_prio = 3'd2;
    bus.sw_set = 8'h10; tick(); bus.sw_set = '0;
    n_checks++; if (bus.pending !== 8'h10) begin n_fail++; $display("FAIL thresh_pending: got %h want 10", bus.pending); end
    tick(); tick();
    n_checks++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL thresh_equal: got %b want 0", bus.req_valid); end
    bus.current_prio = 3'd1;
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd4) begin
      n_fail++; $display("FAIL thresh_lower: got v=%b id=%0d want v=1 id=4", bus.req_valid, bus.req_id); end
    bus.irq_enable[4] = 1'b0;
    tick();
    n_checks++; if (bus.req_valid !== 1'b0 || bus.pending !== 8'h10) begin
      n_fail++; $display("FAIL thresh_disable: got v=%b pend=%h want v=0 pend=10", bus.req_valid, bus.pending); end
    bus.irq_enable = 8'hFF;
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd4) begin
      n_fail++; $display("FAIL thresh_reenable: got v=%b id=%0d want v=1 id=4", bus.req_valid, bus.req_id); end
    bus.sw_clear = 8'h10; tick(); bus.sw_clear = '0;
    bus.current_prio = '0;
    tick();
    n_checks++; if (bus.req_valid !== 1'b0 || bus.pending !== 8'h00 || bus.irq_clear !== 8'h00) begin
      n_fail++; $display("FAIL thresh_swclear: got v=%b pend=%h clr=%h want 0 00 00", bus.req_valid, bus.pending, bus.irq_clear); end
    bus.irq_prio = '0;
  endtask

  task automatic test_simultaneous();
    set_prio(3, 5);
    bus.irq_set[3] = 1'b1;
    tick(); tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd3) begin
      n_fail++; $display("FAIL simul_req: got v=%b id=%0d want v=1 id=3", bus.req_valid, bus.req_id); end
    bus.irq_set[3] = 1'b0;
    tick();
    bus.irq_set[3] = 1'b1;
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h08 || bus.pending !== 8'h08 || bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL simul_ack: got clr=%h pend=%h v=%b want 08 08 0", bus.irq_clear, bus.pending, bus.req_valid); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd3 || bus.irq_clear !== 8'h00) begin
      n_fail++; $display("FAIL simul_represent: got v=%b id=%0d clr=%h want 1 3 00", bus.req_valid, bus.req_id, bus.irq_clear); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL simul_drain: got %h want 00", bus.pending); end
    bus.irq_set = '0;
    bus.sw_set = 8'h80; bus.sw_clear = 8'h80;
    tick();
    bus.sw_set = '0; bus.sw_clear = '0;
    n_checks++; if (bus.pending !== 8'h80) begin n_fail++; $display("FAIL simul_set_wins: got %h want 80", bus.pending); end
    bus.sw_clear = 8'h80; tick(); bus.sw_clear = '0;
    bus.irq_prio = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_prio(0, 3); set_prio(5, 4);
    bus.sw_set = 8'h21; tick(); bus.sw_set = '0;
    bus.irq_set[0] = 1'b1;
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd5 || bus.pending !== 8'h21) begin
      n_fail++; $display("FAIL rmid_req: got v=%b id=%0d pend=%h want 1 5 21", bus.req_valid, bus.req_id, bus.pending); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (bus.pending !== 8'h00 || bus.req_valid !== 1'b0 || bus.irq_clear !== 8'h00) begin
      n_fail++; $display("FAIL rmid_reset: got pend=%h v=%b clr=%h want 00 0 00", bus.pending, bus.req_valid, bus.irq_clear); end
    tick(); tick();
    n_checks++; if (bus.pending !== 8'h00 || bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_held: got pend=%h v=%b want 00 0", bus.pending, bus.req_valid); end
    bus.irq_set[0] = 1'b0; tick();
    bus.irq_set[0] = 1'b1; tick();
    n_checks++; if (bus.pending !== 8'h01) begin n_fail++; $display("FAIL rmid_rerise: got %h want 01", bus.pending); end
    tick();
    n_checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 3'd0) begin
      n_fail++; $display("FAIL rmid_rereq: got v=%b id=%0d want 1 0", bus.req_valid, bus.req_id); end
    bus.take = 1'b1; reset = 1'b1; tick(); bus.take = 1'b0; reset = 1'b0;
    n_checks++; if (bus.irq_clear !== 8'h00 || bus.req_valid !== 1'b0 || bus.pending !== 8'h00) begin
      n_fail++; $display("FAIL rmid_take_reset: got clr=%h v=%b pend=%h want 00 0 00", bus.irq_clear, bus.req_valid, bus.pending); end
    tick();
    n_checks++; if (bus.irq_clear !== 8'h00) begin n_fail++; $display("FAIL rmid_no_late_clear: got %h want 00", bus.irq_clear); end
    bus.irq_set = '0; bus.irq_prio = '0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) set_prio(i, int'($urandom_range(0, 7)));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_checks++; if (bus.req_valid !== m_valid) begin
        n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, bus.req_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (bus.req_id !== IW'(m_id) || bus.req_prio !== PW'(m_prio)) begin
          n_fail++; $display("FAIL rand_req cyc %0d: got id=%0d p=%0d want id=%0d p=%0d", cyc, bus.req_id, bus.req_prio, m_id, m_prio); end
      end
      n_checks++; if (bus.irq_clear !== m_clear) begin
        n_fail++; $display("FAIL rand_clear cyc %0d: got %h want %h", cyc, bus.irq_clear, m_clear); end
      n_checks++; if (bus.pending !== m_pend) begin
        n_fail++; $display("FAIL rand_pending cyc %0d: got %h want %h", cyc, bus.pending, m_pend); end
      n_checks++; if ($countones(bus.irq_clear) > 1) begin
        n_fail++; $display("FAIL rand_clear_onehot cyc %0d: got %h want at most one bit", cyc, bus.irq_clear); end

      if ($urandom_range(0, 2) == 0) bus.irq_set[$urandom_range(0, N-1)] ^= 1'b1;
      bus.sw_set   = ($urandom_range(0, 9) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
      bus.sw_clear = ($urandom_range(0, 9) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
      bus.take     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) bus.current_prio = PW'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) bus.irq_enable = ($urandom_range(0, 1) == 0) ? 8'hFF : N'($urandom);
      if ($urandom_range(0, 49) == 0) set_prio(int'($urandom_range(0, N-1)), int'($urandom_range(0, 7)));
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    bus.take = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.irq_set      = '0;
    bus.irq_enable   = 8'hFF;
    bus.irq_prio     = '0;
    bus.sw_set       = '0;
    bus.sw_clear     = '0;
    bus.current_prio = '0;
    bus.take         = 1'b0;
    tick();
    test_reset();
    test_single();
    test_priority();
    test_preempt();
    test_threshold();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
